// File: rtl/stereo_i2c_cfg_scheduler.sv
// rtl/stereo_i2c_cfg_scheduler.sv - round-robin I2C register loader for the left/right MT9V034 LUTs
module stereo_i2c_cfg_scheduler #(
  parameter logic [7:0]  DEV_ADDR_L    = 8'h90,
  parameter logic [7:0]  DEV_ADDR_R    = 8'h98,
  parameter int unsigned POWERUP_DELAY = 1000000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned RETRY_GAP     = 10000
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic        lut_sel,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  input  logic [7:0]  lut_size_l,
  input  logic [7:0]  lut_size_r,
  output logic        txn_req,
  output logic [7:0]  txn_dev,
  output logic [7:0]  txn_reg,
  output logic [15:0] txn_wdata,
  input  logic        txn_done,
  input  logic        txn_nack,
  output logic        cfg_done_l,
  output logic        cfg_done_r,
  output logic        cfg_done,
  output logic [1:0]  cfg_err
);

  typedef enum logic [2:0] {S_PWRUP, S_ARB, S_LOAD, S_ISSUE, S_GAP, S_DONE} state_t;

  localparam logic [31:0] PWR_LAST   = 32'(POWERUP_DELAY);
  localparam logic [31:0] GAP_LAST   = 32'(RETRY_GAP - 1);
  localparam logic [7:0]  RETRY_LAST = 8'(MAX_RETRY - 1);

  state_t      state, state_next;
  logic [31:0] dly_cnt;
  logic [7:0]  idx_l, idx_r, retry;
  logic        err_l, err_r, rr, pend_restart;
  logic        pend_l, pend_r, pick, do_restart;

  // rr holds the side that wins when both LUTs still have entries
  always_comb begin
    pend_l     = (idx_l < lut_size_l) & ~err_l;
    pend_r     = (idx_r < lut_size_r) & ~err_r;
    pick       = (pend_l & pend_r) ? rr : pend_r;
    do_restart = 1'b0;
    case (state)
      S_PWRUP, S_ARB, S_DONE: do_restart = cfg_start;
      S_LOAD, S_GAP:          do_restart = cfg_start | pend_restart;
      S_ISSUE:                do_restart = (cfg_start | pend_restart) & txn_done;
      default:                do_restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) state <= S_PWRUP;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (do_restart) begin
      state_next = S_PWRUP;
    end else begin
      case (state)
        S_PWRUP: if (dly_cnt == PWR_LAST) state_next = S_ARB;
        S_ARB:   state_next = (pend_l | pend_r) ? S_LOAD : S_DONE;
        S_LOAD:  state_next = S_ISSUE;
        S_ISSUE: if (txn_done) state_next = (txn_nack && retry != RETRY_LAST) ? S_GAP : S_ARB;
        S_GAP:   if (dly_cnt == GAP_LAST) state_next = S_ISSUE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    txn_req  = (state == S_ISSUE);
    cfg_done = cfg_done_l & cfg_done_r;
    cfg_err  = {err_r, err_l};
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt      <= '0;
      idx_l        <= '0;
      idx_r        <= '0;
      retry        <= '0;
      err_l        <= 1'b0;
      err_r        <= 1'b0;
      rr           <= 1'b0;
      pend_restart <= 1'b0;
      cfg_done_l   <= 1'b0;
      cfg_done_r   <= 1'b0;
      lut_sel      <= 1'b0;
      lut_index    <= '0;
      txn_dev      <= '0;
      txn_reg      <= '0;
      txn_wdata    <= '0;
    end else if (do_restart) begin
      dly_cnt      <= '0;
      idx_l        <= '0;
      idx_r        <= '0;
      retry        <= '0;
      err_l        <= 1'b0;
      err_r        <= 1'b0;
      rr           <= 1'b0;
      pend_restart <= 1'b0;
      cfg_done_l   <= 1'b0;
      cfg_done_r   <= 1'b0;
    end else begin
      if (state_next != state)                    dly_cnt <= '0;
      else if (state == S_PWRUP || state == S_GAP) dly_cnt <= dly_cnt + 32'd1;
      // a running bus transfer is never cut short; the restart waits for txn_done
      if (state == S_ISSUE && cfg_start) pend_restart <= 1'b1;
      if (state != S_PWRUP) begin
        cfg_done_l <= (idx_l == lut_size_l) | err_l;
        cfg_done_r <= (idx_r == lut_size_r) | err_r;
      end
      case (state)
        S_ARB: if (pend_l | pend_r) begin
          lut_sel   <= pick;
          lut_index <= pick ? idx_r : idx_l;
        end
        S_LOAD: begin
          txn_dev   <= lut_sel ? DEV_ADDR_R : DEV_ADDR_L;
          txn_reg   <= lut_data[23:16];
          txn_wdata <= lut_data[15:0];
        end
        S_ISSUE: if (txn_done) begin
          if (!txn_nack) begin
            if (lut_sel) idx_r <= idx_r + 8'd1;
            else         idx_l <= idx_l + 8'd1;
            retry <= '0;
            rr    <= ~lut_sel;
          end else if (retry != RETRY_LAST) begin
            retry <= retry + 8'd1;
          end else begin
            if (lut_sel) err_r <= 1'b1;
            else         err_l <= 1'b1;
            retry <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_i2c_cfg_scheduler.sv
// tb/tb_stereo_i2c_cfg_scheduler.sv - directed vector bench for stereo_i2c_cfg_scheduler
module tb_stereo_i2c_cfg_scheduler;

  localparam int P   = 20;
  localparam int G   = 8;
  localparam int TMO = 400;

  logic        clk_ref = 1'b0;
  logic        rst_n, cfg_start, lut_sel, txn_req, txn_done, txn_nack;
  logic [7:0]  lut_index, lut_size_l, lut_size_r, txn_dev, txn_reg;
  logic [23:0] lut_data;
  logic [15:0] txn_wdata;
  logic        cfg_done_l, cfg_done_r, cfg_done;
  logic [1:0]  cfg_err;
  logic [46:0] outs;

  always #5 clk_ref = ~clk_ref;

  assign lut_data = lut_sel ? {8'hB0 + lut_index, 16'h2000 + 16'(lut_index)}
                            : {8'hA0 + lut_index, 16'h1000 + 16'(lut_index)};
  assign outs = {lut_sel, lut_index, txn_req, txn_dev, txn_reg, txn_wdata,
                 cfg_done_l, cfg_done_r, cfg_done, cfg_err};

  stereo_i2c_cfg_scheduler #(
    .POWERUP_DELAY(P), .MAX_RETRY(3), .RETRY_GAP(G)
  ) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .cfg_start(cfg_start),
    .lut_sel(lut_sel), .lut_index(lut_index), .lut_data(lut_data),
    .lut_size_l(lut_size_l), .lut_size_r(lut_size_r),
    .txn_req(txn_req), .txn_dev(txn_dev), .txn_reg(txn_reg), .txn_wdata(txn_wdata),
    .txn_done(txn_done), .txn_nack(txn_nack),
    .cfg_done_l(cfg_done_l), .cfg_done_r(cfg_done_r), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  typedef struct {
    int          tid;
    logic        nack;
    logic [7:0]  dev;
    logic [7:0]  rg;
    logic [15:0] wd;
    int          min_idle;
  } vec_t;

  vec_t vec[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(int tid, logic nack, logic [7:0] dev, logic [7:0] rg,
                              logic [15:0] wd, int min_idle);
    vec_t v;
    v.tid = tid; v.nack = nack; v.dev = dev; v.rg = rg; v.wd = wd; v.min_idle = min_idle;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic do_reset(input logic [7:0] sl, input logic [7:0] sr);
    rst_n = 1'b0; cfg_start = 1'b0; txn_done = 1'b0; txn_nack = 1'b0;
    lut_size_l = sl; lut_size_r = sr;
    repeat (2) @(posedge clk_ref);
    #1;
    check("reset_outs", 64'(outs), 64'd0);
    @(negedge clk_ref);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output int idle);
    idle = 0;
    while (!txn_req && idle < TMO) begin
      @(posedge clk_ref);
      #1;
      idle++;
    end
  endtask

  task automatic serve(input vec_t v);
    int idle;
    check("done_before", 64'(cfg_done), 64'd0);
    wait_req(idle);
    if (!txn_req) begin
      check("req_timeout", 64'(txn_req), 64'd1);
      return;
    end
    check("txn_fields", {24'd0, txn_dev, txn_reg, txn_wdata}, {24'd0, v.dev, v.rg, v.wd});
    if (v.min_idle > 0) check("idle_gap", 64'(idle >= v.min_idle), 64'd1);
    repeat (2) begin @(posedge clk_ref); #1; end
    check("req_held", {31'd0, txn_req, txn_dev, txn_reg, txn_wdata}, {31'd0, 1'b1, v.dev, v.rg, v.wd});
    txn_done = 1'b1; txn_nack = v.nack;
    @(posedge clk_ref);
    #1;
    txn_done = 1'b0; txn_nack = 1'b0;
    check("req_drop", 64'(txn_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] sz_l [4];
    logic [7:0] sz_r [4];
    logic [1:0] exp_err [4];
    int idle, cyc, req_cycles;
    logic saw_req;

    sz_l = '{8'd0, 8'd3, 8'd1, 8'd2};
    sz_r = '{8'd0, 8'd2, 8'd1, 8'd2};
    exp_err = '{2'b00, 2'b00, 2'b00, 2'b10};

    vec.push_back(mk(1, 1'b0, 8'h90, 8'hA0, 16'h1000, 0));
    vec.push_back(mk(1, 1'b0, 8'h98, 8'hB0, 16'h2000, 0));
    vec.push_back(mk(1, 1'b0, 8'h90, 8'hA1, 16'h1001, 0));
    vec.push_back(mk(1, 1'b0, 8'h98, 8'hB1, 16'h2001, 0));
    vec.push_back(mk(1, 1'b0, 8'h90, 8'hA2, 16'h1002, 0));
    vec.push_back(mk(2, 1'b1, 8'h90, 8'hA0, 16'h1000, 0));
    vec.push_back(mk(2, 1'b1, 8'h90, 8'hA0, 16'h1000, G));
    vec.push_back(mk(2, 1'b0, 8'h90, 8'hA0, 16'h1000, G));
    vec.push_back(mk(2, 1'b0, 8'h98, 8'hB0, 16'h2000, 0));
    vec.push_back(mk(3, 1'b0, 8'h90, 8'hA0, 16'h1000, 0));
    vec.push_back(mk(3, 1'b1, 8'h98, 8'hB0, 16'h2000, 0));
    vec.push_back(mk(3, 1'b1, 8'h98, 8'hB0, 16'h2000, G));
    vec.push_back(mk(3, 1'b1, 8'h98, 8'hB0, 16'h2000, G));
    vec.push_back(mk(3, 1'b0, 8'h90, 8'hA1, 16'h1001, 0));

    for (int t = 1; t <= 3; t++) begin
      do_reset(sz_l[t], sz_r[t]);
      foreach (vec[i]) if (vec[i].tid == t) serve(vec[i]);
      repeat (3) begin @(posedge clk_ref); #1; end
      check("final_done", 64'(cfg_done), 64'd1);
      check("final_err", 64'(cfg_err), 64'(exp_err[t]));
      req_cycles = 0;
      repeat (4 * G) begin
        @(posedge clk_ref);
        #1;
        if (txn_req) req_cycles++;
      end
      check("no_extra_txn", 64'(req_cycles), 64'd0);
    end

    // empty LUTs: done lands a fixed number of cycles after reset release
    do_reset(8'd0, 8'd0);
    cyc = 0;
    saw_req = 1'b0;
    while (!cfg_done && cyc < TMO) begin
      @(posedge clk_ref);
      #1;
      cyc++;
      saw_req |= txn_req;
    end
    check("pwrup_latency", 64'(cyc), 64'(P + 2));
    check("empty_no_req", 64'(saw_req), 64'd0);
    check("empty_err", 64'(cfg_err), 64'd0);

    // restart requested while L1 is on the bus
    do_reset(8'd3, 8'd2);
    serve(mk(5, 1'b0, 8'h90, 8'hA0, 16'h1000, 0));
    serve(mk(5, 1'b0, 8'h98, 8'hB0, 16'h2000, 0));
    wait_req(idle);
    check("l1_fields", {40'd0, txn_dev, txn_reg}, {40'd0, 8'h90, 8'hA1});
    cfg_start = 1'b1;
    @(posedge clk_ref);
    #1;
    cfg_start = 1'b0;
    repeat (3) begin @(posedge clk_ref); #1; end
    check("req_held_restart", 64'(txn_req), 64'd1);
    txn_done = 1'b1;
    @(posedge clk_ref);
    #1;
    txn_done = 1'b0;
    check("restart_req_drop", 64'(txn_req), 64'd0);
    check("restart_flags", {59'd0, cfg_done_l, cfg_done_r, cfg_done, cfg_err}, 64'd0);
    serve(mk(5, 1'b0, 8'h90, 8'hA0, 16'h1000, P + 1));

    // asynchronous reset while R1 is requested
    serve(mk(6, 1'b0, 8'h98, 8'hB0, 16'h2000, 0));
    serve(mk(6, 1'b0, 8'h90, 8'hA1, 16'h1001, 0));
    wait_req(idle);
    check("r1_state", {46'd0, lut_sel, lut_index, txn_req, txn_dev},
                      {46'd0, 1'b1, 8'd1, 1'b1, 8'h98});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 64'(outs), 64'd0);
    @(negedge clk_ref);
    rst_n = 1'b1;
    serve(mk(6, 1'b0, 8'h90, 8'hA0, 16'h1000, P + 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
